// File: rtl/traffic_pkg.sv
// Shared definitions for the demand-driven junction phase scheduler:
// lamp encodings, phase codes and request slot indices.
package traffic_pkg;

    // Lamp group encoding, one-hot {red, amber, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] AMB = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Phase codes; the encoding is visible on the phase output.
    typedef enum logic [2:0] {
        PH_MAIN   = 3'd0,
        PH_MAIN_Y = 3'd1,
        PH_ALLRED = 3'd2,
        PH_TURN   = 3'd3,
        PH_TURN_Y = 3'd4,
        PH_SIDE   = 3'd5,
        PH_SIDE_Y = 3'd6,
        PH_PED    = 3'd7
    } phase_e;

    // Request slot order, also the round-robin search order.
    localparam int REQ_MT  = 0;
    localparam int REQ_S   = 1;
    localparam int REQ_PED = 2;

    // Green phase that serves a one-hot grant; an empty grant maps to MAIN.
    function automatic phase_e green_of(input logic [2:0] gnt);
        if (gnt[REQ_MT])       return PH_TURN;
        else if (gnt[REQ_S])   return PH_SIDE;
        else if (gnt[REQ_PED]) return PH_PED;
        else                   return PH_MAIN;
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Three-way round-robin arbiter over the pending minor-phase requests.
// Search order MT -> S -> PED, starting one slot after the last grant.
//
// Handshake: valid_o is high whenever any pend_i bit is set and gnt_o then
// holds the one-hot winner. The pointer moves only on a cycle where grant_i
// and valid_o are both high; grant_i with valid_o low is ignored.
module tlc_rr_arbiter
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pend_i,
    input  logic       grant_i,
    output logic [2:0] gnt_o,
    output logic       valid_o
);

    logic [1:0] ptr_q, ptr_d;

    // Pick the first pending slot at or after the pointer, wrapping around.
    always_comb begin
        gnt_o = 3'b000;
        case (ptr_q)
            2'd1: begin
                if (pend_i[REQ_S])        gnt_o[REQ_S]   = 1'b1;
                else if (pend_i[REQ_PED]) gnt_o[REQ_PED] = 1'b1;
                else if (pend_i[REQ_MT])  gnt_o[REQ_MT]  = 1'b1;
            end
            2'd2: begin
                if (pend_i[REQ_PED])      gnt_o[REQ_PED] = 1'b1;
                else if (pend_i[REQ_MT])  gnt_o[REQ_MT]  = 1'b1;
                else if (pend_i[REQ_S])   gnt_o[REQ_S]   = 1'b1;
            end
            default: begin
                if (pend_i[REQ_MT])       gnt_o[REQ_MT]  = 1'b1;
                else if (pend_i[REQ_S])   gnt_o[REQ_S]   = 1'b1;
                else if (pend_i[REQ_PED]) gnt_o[REQ_PED] = 1'b1;
            end
        endcase
    end

    assign valid_o = |pend_i;

    // Next search start is the slot after the one just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_i && valid_o) begin
            if (gnt_o[REQ_MT])     ptr_d = 2'd1;
            else if (gnt_o[REQ_S]) ptr_d = 2'd2;
            else                   ptr_d = 2'd0;
        end
    end

    // Pointer register; reset starts the search at MT.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven junction phase scheduler. Main road rests green; turn, side
// and pedestrian phases are served on request through a round-robin arbiter,
// always returning to main green in between. Emergency preemption forces a
// return to main green without truncating amber or all-red clearance.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MAIN_MIN = 20,
    parameter int YEL      = 3,
    parameter int ALLRED   = 2,
    parameter int TURN_T   = 8,
    parameter int SIDE_T   = 10,
    parameter int PED_T    = 6,
    parameter int TW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_MT,
    input  logic          req_S,
    input  logic          req_ped,
    input  logic          emg,
    output logic [2:0]    light_M1,
    output logic [2:0]    light_M2,
    output logic [2:0]    light_MT,
    output logic [2:0]    light_S,
    output logic          walk,
    output logic          emg_ack,
    output logic [2:0]    phase,
    output logic [TW-1:0] count
);

    localparam logic [TW-1:0] LD_MAIN = TW'(MAIN_MIN - 1);
    localparam logic [TW-1:0] LD_YEL  = TW'(YEL - 1);
    localparam logic [TW-1:0] LD_AR   = TW'(ALLRED - 1);
    localparam logic [TW-1:0] LD_TURN = TW'(TURN_T - 1);
    localparam logic [TW-1:0] LD_SIDE = TW'(SIDE_T - 1);
    localparam logic [TW-1:0] LD_PED  = TW'(PED_T - 1);

    phase_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    gnt_q, gnt_d;
    logic          from_main_q, from_main_d;
    logic          emg_ack_q;

    logic [2:0]    req_vec;
    logic [2:0]    green_mask;
    logic [2:0]    enter_mask;
    logic [2:0]    arb_gnt;
    logic          arb_valid;
    logic          arb_take;
    logic          cnt_zero;

    // Timer load value for the first cycle of each phase.
    function automatic logic [TW-1:0] load_of(input phase_e p);
        case (p)
            PH_MAIN:                        return LD_MAIN;
            PH_MAIN_Y, PH_TURN_Y, PH_SIDE_Y: return LD_YEL;
            PH_ALLRED:                      return LD_AR;
            PH_TURN:                        return LD_TURN;
            PH_SIDE:                        return LD_SIDE;
            PH_PED:                         return LD_PED;
            default:                        return LD_MAIN;
        endcase
    endfunction

    assign req_vec  = {req_ped, req_S, req_MT};
    assign cnt_zero = (cnt_q == '0);

    tlc_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .pend_i  (pend_q),
        .grant_i (arb_take),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    // Next-phase selection; the grant is latched when main green is left.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        from_main_d = from_main_q;
        arb_take    = 1'b0;
        case (state_q)
            PH_MAIN: begin
                if (cnt_zero && !emg && arb_valid) begin
                    state_d  = PH_MAIN_Y;
                    arb_take = 1'b1;
                    gnt_d    = arb_gnt;
                end
            end
            PH_MAIN_Y: begin
                if (cnt_zero) begin
                    state_d     = PH_ALLRED;
                    from_main_d = 1'b1;
                end
            end
            PH_ALLRED: begin
                if (cnt_zero) begin
                    if (from_main_q && !emg) state_d = green_of(gnt_q);
                    else                     state_d = PH_MAIN;
                end
            end
            PH_TURN:   if (cnt_zero || emg) state_d = PH_TURN_Y;
            PH_SIDE:   if (cnt_zero || emg) state_d = PH_SIDE_Y;
            PH_TURN_Y, PH_SIDE_Y: begin
                if (cnt_zero) begin
                    state_d     = PH_ALLRED;
                    from_main_d = 1'b0;
                end
            end
            PH_PED: begin
                // No amber for pedestrians: emergency goes straight to clearance.
                if (cnt_zero || emg) begin
                    state_d     = PH_ALLRED;
                    from_main_d = 1'b0;
                end
            end
            default: state_d = PH_MAIN;
        endcase
    end

    // Timer reloads on every phase change, otherwise counts down and holds at 0.
    always_comb begin
        if (state_d != state_q) cnt_d = load_of(state_d);
        else if (!cnt_zero)     cnt_d = cnt_q - TW'(1);
        else                    cnt_d = cnt_q;
    end

    // Sticky pending bits: set by requests unless that phase is already green,
    // cleared (winning over a same-edge request) on entry to their green.
    always_comb begin
        green_mask          = 3'b000;
        green_mask[REQ_MT]  = (state_q == PH_TURN);
        green_mask[REQ_S]   = (state_q == PH_SIDE);
        green_mask[REQ_PED] = (state_q == PH_PED);
        enter_mask          = 3'b000;
        enter_mask[REQ_MT]  = (state_d == PH_TURN) && (state_q != PH_TURN);
        enter_mask[REQ_S]   = (state_d == PH_SIDE) && (state_q != PH_SIDE);
        enter_mask[REQ_PED] = (state_d == PH_PED)  && (state_q != PH_PED);
        pend_d              = (pend_q | (req_vec & ~green_mask)) & ~enter_mask;
    end

    // State, timer, pending, grant and acknowledge registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PH_MAIN;
            cnt_q       <= LD_MAIN;
            pend_q      <= 3'b000;
            gnt_q       <= 3'b000;
            from_main_q <= 1'b0;
            emg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            gnt_q       <= gnt_d;
            from_main_q <= from_main_d;
            emg_ack_q   <= (state_d == PH_MAIN) && emg;
        end
    end

    // Moore lamp decode of the current phase.
    always_comb begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
        walk     = 1'b0;
        case (state_q)
            PH_MAIN:   begin light_M1 = GRN; light_M2 = GRN; end
            PH_MAIN_Y: begin light_M1 = AMB; light_M2 = AMB; end
            PH_TURN:   light_MT = GRN;
            PH_TURN_Y: light_MT = AMB;
            PH_SIDE:   light_S  = GRN;
            PH_SIDE_Y: light_S  = AMB;
            PH_PED:    walk     = 1'b1;
            default:   ;
        endcase
    end

    assign emg_ack = emg_ack_q;
    assign phase   = state_q;
    assign count   = cnt_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus a randomized
// run against a phase-level reference model of the junction rules.
module tb_traffic_phase_scheduler;

    localparam int MAIN_MIN = 4;
    localparam int YEL      = 2;
    localparam int ALLRED   = 1;
    localparam int TURN_T   = 3;
    localparam int SIDE_T   = 3;
    localparam int PED_T    = 2;
    localparam int TW       = 8;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] AMB = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [2:0] R_MT  = 3'b001;
    localparam logic [2:0] R_S   = 3'b010;
    localparam logic [2:0] R_PED = 3'b100;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_MT = 1'b0, req_S = 1'b0, req_ped = 1'b0, emg = 1'b0;
    logic [2:0]    light_M1, light_M2, light_MT, light_S;
    logic          walk, emg_ack;
    logic [2:0]    phase;
    logic [TW-1:0] count;
    logic [11:0]   lamps;

    always #5 clk = ~clk;

    assign lamps = {light_M1, light_M2, light_MT, light_S};

    traffic_phase_scheduler #(
        .MAIN_MIN (MAIN_MIN), .YEL (YEL), .ALLRED (ALLRED),
        .TURN_T (TURN_T), .SIDE_T (SIDE_T), .PED_T (PED_T), .TW (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_MT   (req_MT),
        .req_S    (req_S),
        .req_ped  (req_ped),
        .emg      (emg),
        .light_M1 (light_M1),
        .light_M2 (light_M2),
        .light_MT (light_MT),
        .light_S  (light_S),
        .walk     (walk),
        .emg_ack  (emg_ack),
        .phase    (phase),
        .count    (count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Phase durations indexed by phase code, green phase per request slot.
    int dur[8] = '{MAIN_MIN, YEL, ALLRED, TURN_T, YEL, SIDE_T, YEL, PED_T};
    int gph[3] = '{3, 5, 7};

    int       m_phase, m_left, m_ptr, m_gnt;
    bit       m_after_main, m_ack;
    bit [2:0] m_pend;

    function automatic logic [11:0] exp_lamps(input int ph);
        case (ph)
            0:       return {GRN, GRN, RED, RED};
            1:       return {AMB, AMB, RED, RED};
            3:       return {RED, RED, GRN, RED};
            4:       return {RED, RED, AMB, RED};
            5:       return {RED, RED, RED, GRN};
            6:       return {RED, RED, RED, AMB};
            default: return {RED, RED, RED, RED};
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit [2:0] rq, input bit e);
        int np;
        int pick;
        if (r) begin
            m_phase = 0; m_left = MAIN_MIN - 1; m_pend = 3'b000;
            m_ptr = 0; m_gnt = 0; m_after_main = 1'b0; m_ack = 1'b0;
        end else begin
            np = m_phase;
            case (m_phase)
                0: if (m_left == 0 && !e && m_pend != 3'b000) begin
                       pick = -1;
                       for (int k = 0; k < 3; k++)
                           if (pick < 0 && m_pend[(m_ptr + k) % 3]) pick = (m_ptr + k) % 3;
                       m_gnt = pick;
                       m_ptr = (pick + 1) % 3;
                       np = 1;
                   end
                1: if (m_left == 0) begin np = 2; m_after_main = 1'b1; end
                2: if (m_left == 0) np = (m_after_main && !e) ? gph[m_gnt] : 0;
                3, 5: if (m_left == 0 || e) np = m_phase + 1;
                4, 6: if (m_left == 0) begin np = 2; m_after_main = 1'b0; end
                7: if (m_left == 0 || e) begin np = 2; m_after_main = 1'b0; end
                default: np = 0;
            endcase
            for (int i = 0; i < 3; i++) begin
                if (rq[i] && m_phase != gph[i]) m_pend[i] = 1'b1;
                if (np != m_phase && np == gph[i]) m_pend[i] = 1'b0;
            end
            if (np != m_phase) m_left = dur[np] - 1;
            else if (m_left > 0) m_left = m_left - 1;
            m_ack   = (np == 0) && e;
            m_phase = np;
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input bit r, input bit [2:0] rq, input bit e);
        @(negedge clk);
        rst = r; req_MT = rq[0]; req_S = rq[1]; req_ped = rq[2]; emg = e;
        @(posedge clk);
        model_edge(r, rq, e);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(1'b1, 3'b000, 1'b1);
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
        n_checks++; if (count !== TW'(MAIN_MIN - 1)) begin n_fail++; $display("FAIL reset_count: got %0d want %0d", count, MAIN_MIN - 1); end
        n_checks++; if (lamps !== {GRN, GRN, RED, RED}) begin n_fail++; $display("FAIL reset_lamps: got %h want %h", lamps, {GRN, GRN, RED, RED}); end
        n_checks++; if (walk !== 1'b0) begin n_fail++; $display("FAIL reset_walk: got %b want 0", walk); end
        n_checks++; if (emg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_emg_ack: got %b want 0", emg_ack); end
    endtask

    task automatic test_idle();
        int want;
        tick(1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 50; i++) begin
            want = (i < MAIN_MIN - 1) ? (MAIN_MIN - 1 - i) : 0;
            n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL idle_phase c%0d: got %0d want 0", i, phase); end
            n_checks++; if (count !== TW'(want)) begin n_fail++; $display("FAIL idle_count c%0d: got %0d want %0d", i, count, want); end
            n_checks++; if (lamps !== {GRN, GRN, RED, RED}) begin n_fail++; $display("FAIL idle_lamps c%0d: got %h", i, lamps); end
            tick(1'b0, 3'b000, 1'b0);
        end
    endtask

    task automatic test_side_request();
        logic [2:0] exp_q[$];
        logic [2:0] want;
        int         c;
        exp_q = {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd5, 3'd5, 3'd5,
                 3'd6, 3'd6, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        tick(1'b1, 3'b000, 1'b0);
        c = 0;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if (phase !== want) begin n_fail++; $display("FAIL side_seq c%0d: got %0d want %0d", c, phase, want); end
            n_checks++; if (count !== m_left[TW-1:0]) begin n_fail++; $display("FAIL side_count c%0d: got %0d want %0d", c, count, m_left); end
            tick(1'b0, (c == 0) ? R_S : 3'b000, 1'b0);
            c++;
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        int prev;
        int run;
        int c;
        tick(1'b1, 3'b000, 1'b0);
        prev = 0; run = 1; c = 0;
        while (got.size() < 3 && c < 200) begin
            tick(1'b0, 3'b111, 1'b0);
            c++;
            n_checks++; if (phase !== m_phase[2:0]) begin n_fail++; $display("FAIL rr_phase c%0d: got %0d want %0d", c, phase, m_phase); end
            n_checks++; if (walk !== (m_phase == 7)) begin n_fail++; $display("FAIL rr_walk c%0d: got %b want %b", c, walk, m_phase == 7); end
            if (phase == 3'd0) run++;
            else if (prev == 0) begin
                n_checks++; if (run < MAIN_MIN) begin n_fail++; $display("FAIL rr_main_len: got %0d want >=%0d", run, MAIN_MIN); end
                run = 0;
            end
            if ((phase == 3'd3 || phase == 3'd5 || phase == 3'd7) && int'(phase) != prev) got.push_back(int'(phase));
            prev = int'(phase);
        end
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL rr_timeout: got %0d services want 3", got.size()); end
        else begin
            n_checks++; if (got[0] != 3) begin n_fail++; $display("FAIL rr_order0: got %0d want 3", got[0]); end
            n_checks++; if (got[1] != 5) begin n_fail++; $display("FAIL rr_order1: got %0d want 5", got[1]); end
            n_checks++; if (got[2] != 7) begin n_fail++; $display("FAIL rr_order2: got %0d want 7", got[2]); end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 3'b000, 1'b0);
            n_checks++; if (walk !== (m_phase == 7)) begin n_fail++; $display("FAIL rr_walk_tail: got %b want %b", walk, m_phase == 7); end
        end
    endtask

    task automatic test_preemption();
        bit saw_side;
        tick(1'b1, 3'b000, 1'b0);
        tick(1'b0, R_S, 1'b0);
        for (int i = 0; i < 30 && phase !== 3'd5; i++) tick(1'b0, 3'b000, 1'b0);
        n_checks++; if (phase !== 3'd5) begin n_fail++; $display("FAIL pre_wait_side: got %0d want 5", phase); end
        tick(1'b0, 3'b000, 1'b0);
        n_checks++; if (phase !== 3'd5) begin n_fail++; $display("FAIL pre_side2: got %0d want 5", phase); end
        tick(1'b0, 3'b000, 1'b1);
        n_checks++; if (phase !== 3'd6) begin n_fail++; $display("FAIL pre_side_y: got %0d want 6", phase); end
        n_checks++; if (count !== TW'(YEL - 1)) begin n_fail++; $display("FAIL pre_side_y_count: got %0d want %0d", count, YEL - 1); end
        tick(1'b0, R_MT, 1'b1);
        n_checks++; if (phase !== 3'd6) begin n_fail++; $display("FAIL pre_side_y2: got %0d want 6", phase); end
        tick(1'b0, 3'b000, 1'b1);
        n_checks++; if (phase !== 3'd2) begin n_fail++; $display("FAIL pre_allred: got %0d want 2", phase); end
        tick(1'b0, 3'b000, 1'b1);
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL pre_main: got %0d want 0", phase); end
        n_checks++; if (emg_ack !== 1'b1) begin n_fail++; $display("FAIL pre_ack_entry: got %b want 1", emg_ack); end
        n_checks++; if (count !== TW'(MAIN_MIN - 1)) begin n_fail++; $display("FAIL pre_main_count: got %0d want %0d", count, MAIN_MIN - 1); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 3'b000, 1'b1);
            n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL pre_hold c%0d: got %0d want 0", i, phase); end
            n_checks++; if (emg_ack !== 1'b1) begin n_fail++; $display("FAIL pre_ack_hold c%0d: got %b want 1", i, emg_ack); end
        end
        tick(1'b0, 3'b000, 1'b0);
        n_checks++; if (phase !== 3'd1) begin n_fail++; $display("FAIL pre_release: got %0d want 1", phase); end
        n_checks++; if (emg_ack !== 1'b0) begin n_fail++; $display("FAIL pre_ack_drop: got %b want 0", emg_ack); end
        saw_side = 1'b0;
        for (int i = 0; i < 12 && phase !== 3'd3; i++) begin
            tick(1'b0, 3'b000, 1'b0);
            if (phase == 3'd5) saw_side = 1'b1;
        end
        n_checks++; if (phase !== 3'd3) begin n_fail++; $display("FAIL pre_turn_served: got %0d want 3", phase); end
        n_checks++; if (saw_side !== 1'b0) begin n_fail++; $display("FAIL pre_no_side: got %b want 0", saw_side); end
    endtask

    task automatic test_ped_abort();
        tick(1'b1, 3'b000, 1'b0);
        tick(1'b0, R_PED, 1'b0);
        for (int i = 0; i < 30 && phase !== 3'd7; i++) tick(1'b0, 3'b000, 1'b0);
        n_checks++; if (phase !== 3'd7) begin n_fail++; $display("FAIL ped_wait: got %0d want 7", phase); end
        n_checks++; if (walk !== 1'b1) begin n_fail++; $display("FAIL ped_walk_on: got %b want 1", walk); end
        tick(1'b0, 3'b000, 1'b1);
        n_checks++; if (phase !== 3'd2) begin n_fail++; $display("FAIL ped_abort: got %0d want 2", phase); end
        n_checks++; if (walk !== 1'b0) begin n_fail++; $display("FAIL ped_walk_off: got %b want 0", walk); end
        tick(1'b0, 3'b000, 1'b1);
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL ped_to_main: got %0d want 0", phase); end
        n_checks++; if (emg_ack !== 1'b1) begin n_fail++; $display("FAIL ped_ack: got %b want 1", emg_ack); end
        tick(1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_rst_mid_phase();
        tick(1'b1, 3'b000, 1'b0);
        tick(1'b0, R_MT, 1'b0);
        for (int i = 0; i < 30 && phase !== 3'd3; i++) tick(1'b0, 3'b000, 1'b0);
        n_checks++; if (phase !== 3'd3) begin n_fail++; $display("FAIL rst_wait_turn: got %0d want 3", phase); end
        tick(1'b0, R_S, 1'b0);
        tick(1'b1, 3'b111, 1'b0);
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL rst_phase: got %0d want 0", phase); end
        n_checks++; if (count !== TW'(MAIN_MIN - 1)) begin n_fail++; $display("FAIL rst_count: got %0d want %0d", count, MAIN_MIN - 1); end
        n_checks++; if (lamps !== {GRN, GRN, RED, RED}) begin n_fail++; $display("FAIL rst_lamps: got %h", lamps); end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 3'b000, 1'b0);
            n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL rst_pend_clear c%0d: got %0d want 0", i, phase); end
        end
    endtask

    task automatic test_random();
        bit [2:0] rq;
        bit       e;
        bit       r;
        tick(1'b1, 3'b000, 1'b0);
        e = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) rq[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) e = ~e;
            r = ($urandom_range(0, 999) == 0);
            tick(r, rq, e);
            n_checks++; if (phase !== m_phase[2:0]) begin n_fail++; $display("FAIL rnd_phase c%0d: got %0d want %0d", c, phase, m_phase); end
            n_checks++; if (count !== m_left[TW-1:0]) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, m_left); end
            n_checks++; if (lamps !== exp_lamps(m_phase)) begin n_fail++; $display("FAIL rnd_lamps c%0d: got %h want %h", c, lamps, exp_lamps(m_phase)); end
            n_checks++; if (walk !== (m_phase == 7)) begin n_fail++; $display("FAIL rnd_walk c%0d: got %b want %b", c, walk, m_phase == 7); end
            n_checks++; if (emg_ack !== m_ack) begin n_fail++; $display("FAIL rnd_emg_ack c%0d: got %b want %b", c, emg_ack, m_ack); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle();
        test_side_request();
        test_round_robin();
        test_preemption();
        test_ped_abort();
        test_rst_mid_phase();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-driven phase scheduler for the four-approach junction: main road (M1, M2), main-road turn (MT) and side road (S). Minor phases (turn, side, pedestrian) are served only on request, through a round-robin arbiter. Emergency preemption forces a return to main-road green. It drives the same four 3-bit lamp groups as the fixed-cycle controller and replaces its free-running sequence wherever detector, push-button and preemption inputs exist.

## Interface
- MAIN_MIN, 20: minimum main-green cycles
- YEL, 3: amber cycles, any approach
- ALLRED, 2: all-red clearance cycles
- TURN_T, 8: turn-green cycles
- SIDE_T, 10: side-green cycles
- PED_T, 6: pedestrian walk cycles
- TW, 8: timer width; every duration in 1..2^TW-1
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_MT  in  1  turn-lane detector; pulse or level
- req_S  in  1  side-road detector; pulse or level
- req_ped  in  1  pedestrian push-button; pulse or level
- emg  in  1  emergency preemption; level
- light_M1, light_M2, light_MT, light_S  out  3 each  lamp one-hot {red, amber, green}: 100 / 010 / 001
- walk  out  1  pedestrian walk lamp
- emg_ack  out  1  high while in MAIN with emg high
- phase  out  3  current state code
- count  out  TW  remaining cycles in current state, 0 = last cycle

## Operation
- Phase codes and lamp outputs:
  - MAIN=0: M1, M2 green; MT, S red
  - MAIN_Y=1: M1, M2 amber; MT, S red
  - ALLRED=2: all red
  - TURN=3: MT green; others red
  - TURN_Y=4: MT amber; others red
  - SIDE=5: S green; others red
  - SIDE_Y=6: S amber; others red
  - PED=7: all red, walk=1
- Outputs are Moore decodes of the state register. walk is 0 in every phase except PED.
- Pending bits pend[MT, S, PED] are sticky.
  - A request input high sets its bit.
  - The bit clears on the edge that enters the matching green phase.
  - A request high on that same edge is absorbed; the bit does not re-set.
  - A request for the phase currently green is ignored.
- Round-robin arbiter: order MT → S → PED. It starts searching at the entry after the last-served phase. The pointer advances only on grant.
- Transitions:
  - MAIN: stays while count>0, while emg is high, or while pend==0. Otherwise → MAIN_Y; the arbiter result is latched into a grant register on that edge.
  - MAIN_Y → ALLRED.
  - ALLRED after MAIN_Y → latched grant. If emg is high at exit → MAIN instead.
  - ALLRED after any minor phase → MAIN always; main road gets a green between minor phases.
  - TURN → TURN_Y, SIDE → SIDE_Y, PED → ALLRED when count==0, or immediately on emg.
  - TURN_Y → ALLRED, SIDE_Y → ALLRED.
- Emergency:
  - An amber or all-red in progress is never truncated.
  - PED aborts straight to ALLRED; it has no amber.
  - Pending bits are retained throughout and served after emg falls, with MAIN_MIN counted from MAIN entry.
- Reset state: MAIN, count=MAIN_MIN-1, pend=0, rr pointer=MT.

## Timing
- Every state entered normally lasts exactly its duration N cycles. count loads N-1 on entry and decrements each cycle.
- Outputs after the first edge with rst=1: phase=0, light_M1=light_M2=001, light_MT=light_S=100, walk=0, emg_ack=0, count=MAIN_MIN-1.
- Minimum request-to-green latency, from MAIN with count==0 and the request seen on edge k: MAIN_Y begins at k+1; minor green begins at k+1+YEL+ALLRED.
- emg in a minor green: amber (or ALLRED from PED) begins on the next edge.
- emg_ack rises on the same edge MAIN is entered while emg is high, or the edge after emg rises if already in MAIN.
- rst mid-phase overrides everything on that edge.

## Structure
- Package traffic_pkg holds:
  - lamp encodings RED=3'b100, AMB=3'b010, GRN=3'b001
  - phase codes 0-7 as constants
  - the request index order MT=0, S=1, PED=2
- Sub-module tlc_rr_arbiter: 3-way round-robin with inputs pend[2:0] and a grant strobe, outputs one-hot gnt and valid. The FSM, timer and pending latches stay in the top module.

## Test plan
Use MAIN_MIN=4, YEL=2, ALLRED=1, TURN_T=3, SIDE_T=3, PED_T=2.
- Idle: reset, no requests for 50 cycles → phase stays 0; count goes 3,2,1,0 then holds 0; lamps constant.
- Side request: req_S one-cycle pulse at cycle 1 after reset → phase sequence 0×4, 1×2, 2×1, 5×3, 6×2, 2×1, 0; pend[S] clears on SIDE entry.
- Round robin: req_MT, req_S, req_ped held high together → service order TURN, SIDE, PED; each separated by MAIN≥4 cycles; walk=1 only during the PED cycles.
- Preemption: emg rises in the second SIDE cycle → SIDE_Y next edge, 2 cycles, ALLRED 1, MAIN; emg_ack=1 on entry; req_MT pulsed during emg is served only after emg falls and 4 MAIN cycles elapse.
- PED abort and reset: emg during PED → ALLRED next edge with walk=0. Separately, rst during TURN → next edge phase=0, count=3, pend=0.
